// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter. CPU byte stores land in a small FIFO in
// one cycle. An independent frame state machine drains the FIFO onto
// uartTxPin at CLKS_PER_BIT clocks per bit, running frames back to back.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          wr_en,
  input  logic [7:0]                    wr_data,
  input  logic                          clr_ovf,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          busy,
  output logic                          overflow,
  output logic                          uartTxPin
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t         state_q, state_d;
  logic [15:0]    bit_cnt_q, bit_cnt_d;
  logic [2:0]     idx_q, idx_d;
  logic [7:0]     sh_q, sh_d;
  logic           tx_q, tx_d;
  logic [AW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           full_q, full_d, empty_q, empty_d, ovf_q, ovf_d;
  logic [7:0]     mem_q [FIFO_DEPTH];

  logic push, drop, pop, bit_done;

  // Push/drop decision uses the registered (pre-edge) full flag only.
  assign push     = wr_en & ~full_q;
  assign drop     = wr_en &  full_q;
  assign bit_done = (bit_cnt_q == 16'(CLKS_PER_BIT - 1));

  // Frame sequencer: next state, bit timing, pop and the next line level.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    idx_d     = idx_q;
    sh_d      = sh_q;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty_q) begin
          pop       = 1'b1;
          sh_d      = mem_q[rptr_q];
          bit_cnt_d = '0;
          state_d   = START;
        end
      end
      START: begin
        if (bit_done) begin
          bit_cnt_d = '0;
          idx_d     = '0;
          state_d   = DATA;
        end else begin
          bit_cnt_d = bit_cnt_q + 16'd1;
        end
      end
      DATA: begin
        if (bit_done) begin
          bit_cnt_d = '0;
          if (idx_q == 3'd7) state_d = STOP;
          else               idx_d   = idx_q + 3'd1;
        end else begin
          bit_cnt_d = bit_cnt_q + 16'd1;
        end
      end
      STOP: begin
        if (bit_done) begin
          bit_cnt_d = '0;
          if (!empty_q) begin
            // Chain straight into the next start bit, no idle gap.
            pop     = 1'b1;
            sh_d    = mem_q[rptr_q];
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    // The line level follows the state being entered, so the pin register
    // changes on the same edge as the state.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = sh_d[idx_d];
      default: tx_d = 1'b1;
    endcase
  end

  // FIFO bookkeeping: pointers, explicit occupancy, flags and sticky overflow.
  always_comb begin
    wptr_d = push ? wptr_q + AW'(1) : wptr_q;
    rptr_d = pop  ? rptr_q + AW'(1) : rptr_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    full_d  = (cnt_d == CW'(FIFO_DEPTH));
    empty_d = (cnt_d == '0);
    ovf_d   = drop | (ovf_q & ~clr_ovf);
  end

  // State registers with synchronous reset; reset aborts any frame in flight.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      idx_q     <= '0;
      sh_q      <= '0;
      tx_q      <= 1'b1;
      wptr_q    <= '0;
      rptr_q    <= '0;
      cnt_q     <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      idx_q     <= idx_d;
      sh_q      <= sh_d;
      tx_q      <= tx_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      cnt_q     <= cnt_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
      ovf_q     <= ovf_d;
    end
  end

  // FIFO storage; contents need no reset since the pointers define validity.
  always_ff @(posedge CLK) begin
    if (!RST && push) mem_q[wptr_q] <= wr_data;
  end

  assign full      = full_q;
  assign empty     = empty_q;
  assign count     = cnt_q;
  assign busy      = (state_q != IDLE);
  assign overflow  = ovf_q;
  assign uartTxPin = tx_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: accepted bytes are queued by the
// stimulus, a serial-line monitor decodes frames and checks them in order.
module tb_uart_tx_fifo;
  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       wr_en = 1'b0;
  logic       clr_ovf = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       full, empty, busy, overflow, uartTxPin;
  logic [2:0] count;

  int errs = 0;
  int chks = 0;
  int cyc  = 0;
  logic [7:0] exp_q[$];
  int         start_q[$];

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  uart_tx_fifo #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut (
    .CLK(CLK), .RST(RST), .wr_en(wr_en), .wr_data(wr_data), .clr_ovf(clr_ovf),
    .full(full), .empty(empty), .count(count), .busy(busy),
    .overflow(overflow), .uartTxPin(uartTxPin)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic drive(input logic w, input logic [7:0] d, input logic c);
    wr_en = w; wr_data = d; clr_ovf = c;
    step(1);
    wr_en = 1'b0; clr_ovf = 1'b0;
  endtask

  task automatic push(input logic [7:0] d, input bit accepted);
    if (accepted) exp_q.push_back(d);
    drive(1'b1, d, 1'b0);
  endtask

  task automatic wait_idle(input int maxc);
    int n = 0;
    while (!(empty === 1'b1 && busy === 1'b0) && n < maxc) begin step(1); n++; end
    chk("idle_reached", 32'(n < maxc), 1);
    step(3);
  endtask

  // Monitor: decode each frame from its falling start edge, check bit timing
  // and compare the byte against the head of the expected queue.
  initial begin : mon
    logic prev, ab, shape, eb;
    logic [39:0] s;
    logic [7:0] b;
    prev = 1'b1;
    forever begin
      @(negedge CLK);
      if (RST !== 1'b0) prev = 1'b1;
      else if (prev === 1'b1 && uartTxPin === 1'b0) begin
        start_q.push_back(cyc);
        s = '0; ab = 1'b0;
        for (int k = 1; k < 40; k++) begin
          if (!ab) begin
            @(negedge CLK);
            if (RST !== 1'b0) ab = 1'b1;
            else s[k] = uartTxPin;
          end
        end
        if (ab) prev = 1'b1;
        else begin
          shape = 1'b1;
          for (int k = 0; k < 10; k++) begin
            eb = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : s[4*k];
            for (int j = 0; j < 4; j++) if (s[4*k+j] !== eb) shape = 1'b0;
          end
          for (int j = 0; j < 8; j++) b[j] = s[4+4*j];
          chk("frame_shape", 32'(shape), 1);
          chk("frame_expected", 32'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) chk("frame_byte", 32'(b), 32'(exp_q.pop_front()));
          prev = s[39];
        end
      end else prev = uartTxPin;
    end
  end

  initial begin : stim
    int t0, n, guard, bad;
    // Reset state
    step(2);
    RST = 1'b0;
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_pin", 32'(uartTxPin), 1);
    step(2);

    // Single byte: push at cycle 0, start bit cycles 2-5, idle by cycle 42
    start_q.delete();
    push(8'hA5, 1);
    t0 = cyc;
    chk("t1_count_c1", 32'(count), 1);
    chk("t1_empty_c1", 32'(empty), 0);
    step(1);
    chk("t1_count_c2", 32'(count), 0);
    chk("t1_busy_c2", 32'(busy), 1);
    chk("t1_pin_c2", 32'(uartTxPin), 0);
    step(39);
    chk("t1_busy_c41", 32'(busy), 1);
    chk("t1_stop_c41", 32'(uartTxPin), 1);
    step(1);
    chk("t1_busy_c42", 32'(busy), 0);
    chk("t1_start_cyc", start_q.size() > 0 ? 32'(start_q[0] - t0) : 32'hFFFF_FFFF, 1);
    step(3);

    // Back-to-back frames with no gap
    start_q.delete();
    push(8'h55, 1);
    push(8'h0F, 1);
    chk("t2_count_c2", 32'(count), 1);
    step(39);
    chk("t2_empty_c41", 32'(empty), 0);
    step(1);
    chk("t2_empty_c42", 32'(empty), 1);
    chk("t2_pin_c42", 32'(uartTxPin), 0);
    wait_idle(200);
    chk("t2_frames", 32'(start_q.size()), 2);
    if (start_q.size() == 2) chk("t2_gap", 32'(start_q[1] - start_q[0]), 40);

    // Push coinciding with the last-STOP-cycle pop
    push(8'h11, 1);
    push(8'h22, 1);
    chk("t3_count_c2", 32'(count), 1);
    step(39);
    push(8'h33, 1);
    chk("t3_count_pp", 32'(count), 1);
    chk("t3_pin_pp", 32'(uartTxPin), 0);
    wait_idle(300);

    // Full / overflow with depth 4: byte 0 pops at edge 1, byte 5 is dropped
    for (int i = 0; i < 6; i++) begin
      push(8'h60 + 8'(i), i < 5);
      if (i == 4) begin
        chk("t4_full_c5", 32'(full), 1);
        chk("t4_ovf_c5", 32'(overflow), 0);
      end
      if (i == 5) begin
        chk("t4_ovf_c6", 32'(overflow), 1);
        chk("t4_count_c6", 32'(count), 4);
      end
    end
    drive(1'b1, 8'hEE, 1'b1);
    chk("t4_ovf_set_wins", 32'(overflow), 1);
    chk("t4_count_hold", 32'(count), 4);
    drive(1'b0, 8'h00, 1'b1);
    chk("t4_ovf_clr", 32'(overflow), 0);
    wait_idle(400);

    // Wrap-around: stream 10 distinct bytes whenever not full
    n = 0; guard = 0;
    while (n < 10 && guard < 2000) begin
      if (full === 1'b0) begin push(8'(n * 37 + 5), 1); n++; end
      else step(1);
      guard++;
    end
    chk("t5_pushed", 32'(n), 10);
    wait_idle(800);

    // Reset during DATA bit 3 of 0xC6 with two bytes queued
    push(8'hC6, 1);
    push(8'h5A, 1);
    push(8'h3B, 1);
    step(16);
    chk("t6_busy_pre", 32'(busy), 1);
    chk("t6_bit3_pre", 32'(uartTxPin), 0);
    chk("t6_count_pre", 32'(count), 2);
    RST = 1'b1;
    exp_q.delete();
    step(1);
    RST = 1'b0;
    chk("t6_pin_rst", 32'(uartTxPin), 1);
    chk("t6_busy_rst", 32'(busy), 0);
    chk("t6_count_rst", 32'(count), 0);
    chk("t6_empty_rst", 32'(empty), 1);
    bad = 0;
    repeat (100) begin
      step(1);
      if (uartTxPin !== 1'b1 || busy !== 1'b0) bad++;
    end
    chk("t6_quiet", 32'(bad), 0);
    push(8'h3C, 1);
    wait_idle(200);

    chk("exp_q_drained", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end
endmodule
